// File: rtl/seqdet_pkg.sv
// Shared constants, mode enum and sizing helper for the multi-pattern sequence detector.
// Optional match counters are enabled with the SEQDET_MATCH_COUNT_EN macro.
package seqdet_pkg;

    localparam int           DEF_LEN      = 4;
    localparam int           DEF_NPAT     = 2;
    localparam logic [7:0]   DEF_PATTERNS = 8'b1010_0110;
    localparam int           DEF_CNT_W    = 8;

    typedef enum logic {
        SEQ_NONOVERLAP = 1'b0,
        SEQ_OVERLAP    = 1'b1
    } seq_mode_e;

    // Fill counters must hold the value LEN itself, hence LEN+1 states.
    function automatic int fill_width(input int len);
        return $clog2(len + 1);
    endfunction

    localparam int FILL_W = fill_width(DEF_LEN);

endpackage

// File: rtl/seqdet_chan.sv
// One detector channel: fixed pattern, saturating fill counter and registered match pulse.
// With SEQDET_MATCH_COUNT_EN defined, also keeps a saturating per-channel match counter.
module seqdet_chan
    import seqdet_pkg::*;
#(
    parameter int             LEN = DEF_LEN,
    parameter logic [LEN-1:0] PAT = DEF_PATTERNS[DEF_LEN-1:0]
`ifdef SEQDET_MATCH_COUNT_EN
    ,
    parameter int             CNT_W = DEF_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_valid,
    input  logic             clear,
    input  seq_mode_e        mode,
    input  logic [LEN-1:0]   next_hist,
`ifdef SEQDET_MATCH_COUNT_EN
    output logic [CNT_W-1:0] match_cnt,
`endif
    output logic             z
);

    localparam int            FW       = fill_width(LEN);
    localparam logic [FW-1:0] FILL_MAX = FW'(LEN);

    logic [FW-1:0] fill_q, fill_d, fill_next;
    logic          z_q, z_d;
    logic          hit;

    // A match needs LEN bits seen since the last reset/clear (or last match in
    // non-overlap mode), so the all-zero reset history can never fire.
    always_comb begin
        fill_next = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + FW'(1);
        hit       = x_valid && !clear && (next_hist == PAT) && (fill_next >= FILL_MAX);
        fill_d    = fill_q;
        z_d       = 1'b0;
        if (clear) begin
            fill_d = '0;
        end else if (x_valid) begin
            fill_d = fill_next;
            if (hit) begin
                z_d = 1'b1;
                if (mode == SEQ_NONOVERLAP) begin
                    fill_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_q <= '0;
            z_q    <= 1'b0;
        end else begin
            fill_q <= fill_d;
            z_q    <= z_d;
        end
    end

    assign z = z_q;

`ifdef SEQDET_MATCH_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts alongside z so the count is current in the same cycle as the pulse.
    always_comb begin
        cnt_d = cnt_q;
        if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`endif

endmodule

// File: rtl/seqdet_multi.sv
// Multi-pattern serial sequence detector: shared history register feeding NPAT channels.
// Define SEQDET_MATCH_COUNT_EN to add the per-channel match_cnt output.
module seqdet_multi
    import seqdet_pkg::*;
#(
    parameter int                  LEN      = DEF_LEN,
    parameter int                  NPAT     = DEF_NPAT,
    parameter logic [NPAT*LEN-1:0] PATTERNS = DEF_PATTERNS,
    parameter int                  CNT_W    = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  x,
    input  logic                  x_valid,
    input  logic                  clear,
    input  logic                  overlap,
`ifdef SEQDET_MATCH_COUNT_EN
    output logic [NPAT*CNT_W-1:0] match_cnt,
`endif
    output logic [NPAT-1:0]       z
);

    if (LEN < 2 || NPAT < 1 || CNT_W < 1) begin : g_bad_params
        $error("seqdet_multi: invalid LEN/NPAT/CNT_W");
    end

    logic [LEN-1:0] hist_q, hist_d;
    seq_mode_e      mode;

    assign mode = seq_mode_e'(overlap);

    always_comb begin
        hist_d = hist_q;
        if (clear) begin
            hist_d = '0;
        end else if (x_valid) begin
            hist_d = {hist_q[LEN-2:0], x};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    // Channels compare against the next history value so z lands one cycle after the last bit.
    for (genvar k = 0; k < NPAT; k++) begin : g_chan
        seqdet_chan #(
            .LEN   (LEN),
            .PAT   (PATTERNS[k*LEN +: LEN])
`ifdef SEQDET_MATCH_COUNT_EN
            ,
            .CNT_W (CNT_W)
`endif
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .x_valid   (x_valid),
            .clear     (clear),
            .mode      (mode),
            .next_hist (hist_d),
`ifdef SEQDET_MATCH_COUNT_EN
            .match_cnt (match_cnt[k*CNT_W +: CNT_W]),
`endif
            .z         (z[k])
        );
    end

endmodule
